// File: rtl/zigbee_ppdu_framer.sv
// Zigbee PPDU framer: serialises preamble, SFD, PHR and PSDU bytes into 4-bit symbols for a
// downstream FIFO, low nibble first, stalling on FIFO full or an empty payload buffer.
module zigbee_ppdu_framer #(
   parameter int unsigned PREAMBLE_SYMS = 8,
   parameter logic [7:0]  SFD_BYTE      = 8'hA7
) (
   input  logic       inClock,
   input  logic       inReset,
   input  logic       inStart,
   input  logic [6:0] inLength,
   input  logic       inAbort,
   input  logic [7:0] inByte,
   input  logic       inByteValid,
   output logic       outByteReady,
   input  logic       inFull,
   output logic [3:0] outData,
   output logic       outWriteEnable,
   output logic       outBusy,
   output logic       outDone,
   output logic       outError
);

   localparam int unsigned     PreW    = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(PREAMBLE_SYMS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StSfd,
      StPhr,
      StPayload,
      StDone
   } state_e;

   state_e          state_q;
   logic [6:0]      len_q;
   logic [6:0]      byte_cnt_q;
   logic            nib_sel_q;
   logic [PreW-1:0] pre_cnt_q;
   logic [7:0]      buf_q;
   logic            buf_valid_q;
   logic            error_q;

   logic            pending;
   logic [3:0]      nibble;
   logic            wr;
   logic            byte_take;

   always_comb begin
      pending = 1'b0;
      nibble  = 4'h0;
      case (state_q)
         StPreamble: pending = 1'b1;
         StSfd: begin
            pending = 1'b1;
            nibble  = nib_sel_q ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
         end
         StPhr: begin
            pending = 1'b1;
            nibble  = nib_sel_q ? {1'b0, len_q[6:4]} : len_q[3:0];
         end
         StPayload: begin
            // An empty buffer is a gap: nothing pending, nibble stays put.
            pending = buf_valid_q;
            nibble  = nib_sel_q ? buf_q[7:4] : buf_q[3:0];
         end
         default: ;
      endcase
   end

   assign wr             = pending & ~inFull;
   assign byte_take      = inByteValid & outByteReady;
   assign outData        = nibble;
   assign outWriteEnable = wr;
   assign outByteReady   = (state_q == StPayload) & ~buf_valid_q;
   assign outBusy        = (state_q != StIdle);
   assign outDone        = (state_q == StDone);
   assign outError       = error_q;

   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         state_q     <= StIdle;
         len_q       <= 7'd0;
         byte_cnt_q  <= 7'd0;
         nib_sel_q   <= 1'b0;
         pre_cnt_q   <= '0;
         buf_q       <= 8'h00;
         buf_valid_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         error_q <= 1'b0;
         if ((state_q != StIdle) && inAbort) begin
            state_q     <= StIdle;
            buf_valid_q <= 1'b0;
            error_q     <= 1'b1;
         end else begin
            case (state_q)
               StIdle: begin
                  if (inStart) begin
                     len_q       <= inLength;
                     byte_cnt_q  <= 7'd0;
                     nib_sel_q   <= 1'b0;
                     pre_cnt_q   <= '0;
                     buf_valid_q <= 1'b0;
                     state_q     <= StPreamble;
                  end
               end
               StPreamble: begin
                  if (wr) begin
                     if (pre_cnt_q == PreLast) begin
                        pre_cnt_q <= '0;
                        state_q   <= StSfd;
                     end else begin
                        pre_cnt_q <= pre_cnt_q + PreW'(1);
                     end
                  end
               end
               StSfd: begin
                  if (wr) begin
                     nib_sel_q <= ~nib_sel_q;
                     if (nib_sel_q) state_q <= StPhr;
                  end
               end
               StPhr: begin
                  if (wr) begin
                     nib_sel_q <= ~nib_sel_q;
                     if (nib_sel_q) state_q <= (len_q != 7'd0) ? StPayload : StDone;
                  end
               end
               StPayload: begin
                  // byte_take and wr are exclusive: one needs the buffer empty, the other full.
                  if (byte_take) begin
                     buf_q       <= inByte;
                     buf_valid_q <= 1'b1;
                  end
                  if (wr) begin
                     nib_sel_q <= ~nib_sel_q;
                     if (nib_sel_q) begin
                        buf_valid_q <= 1'b0;
                        byte_cnt_q  <= byte_cnt_q + 7'd1;
                        if (byte_cnt_q == len_q - 7'd1) state_q <= StDone;
                     end
                  end
               end
               StDone: state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_zigbee_ppdu_framer.sv
// Randomised bench for zigbee_ppdu_framer: frames are checked against a nibble list built
// from the framing rules, with FIFO stalls, payload gaps, aborts and reset mid-frame.
module tb_zigbee_ppdu_framer;

   logic       inClock = 1'b0;
   logic       inReset = 1'b0;
   logic       inStart = 1'b0;
   logic [6:0] inLength = 7'd0;
   logic       inAbort = 1'b0;
   logic [7:0] inByte = 8'h00;
   logic       inByteValid = 1'b0;
   logic       outByteReady;
   logic       inFull = 1'b0;
   logic [3:0] outData;
   logic       outWriteEnable;
   logic       outBusy;
   logic       outDone;
   logic       outError;

   zigbee_ppdu_framer dut (
      .inClock       (inClock),
      .inReset       (inReset),
      .inStart       (inStart),
      .inLength      (inLength),
      .inAbort       (inAbort),
      .inByte        (inByte),
      .inByteValid   (inByteValid),
      .outByteReady  (outByteReady),
      .inFull        (inFull),
      .outData       (outData),
      .outWriteEnable(outWriteEnable),
      .outBusy       (outBusy),
      .outDone       (outDone),
      .outError      (outError)
   );

   always #5 inClock = ~inClock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Stimulus and observation state shared by tick()/drive()
   logic [7:0] tx_q[$];
   int  got_q[$];
   int  send_idx, gap_idx, gap_len, gap_left, full_mode, full_left;
   bit  gap_used, win0, win1, rand_start, valid_rand, abort_mode, abort_sent, frame_active;
   int  done_cnt, err_cnt, ready_seen, accepted, cyc, last_wr_cyc, done_cyc;
   int  prev_data;
   bit  prev_gap, busy_at_err;

   task automatic drive();
      inStart = rand_start && frame_active && ($urandom_range(0, 3) == 0);
      if (inStart) inLength = 7'($urandom);
      inAbort = 1'b0;
      if (abort_mode && !abort_sent && accepted == 2) begin
         inAbort    = 1'b1;
         abort_sent = 1'b1;
      end
      if (!gap_used && send_idx == gap_idx) begin
         gap_left = gap_len;
         gap_used = 1'b1;
      end
      if (gap_left > 0) begin
         gap_left--;
         inByteValid = 1'b0;
         inByte      = 8'($urandom);
      end else if (send_idx < tx_q.size() && (!valid_rand || $urandom_range(0, 2) != 0)) begin
         inByteValid = 1'b1;
         inByte      = tx_q[send_idx];
      end else begin
         inByteValid = 1'b0;
         inByte      = 8'($urandom);
      end
      if (full_mode == 2) begin
         if (!win0 && got_q.size() == 8) begin
            full_left = 5;
            win0 = 1'b1;
         end
         if (!win1 && got_q.size() == 12) begin
            full_left = 3;
            win1 = 1'b1;
         end
         inFull = (full_left > 0);
         if (full_left > 0) full_left--;
      end else if (full_mode == 1) begin
         inFull = ($urandom_range(0, 3) == 0);
      end else begin
         inFull = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge inClock);
      cyc++;
      if (inFull) check_eq("no_write_while_full", outWriteEnable, 0);
      if (outByteReady) begin
         ready_seen++;
         check_eq("gap_no_write", outWriteEnable, 0);
         if (prev_gap) check_eq("gap_data_stable", outData, prev_data);
      end
      prev_gap  = outByteReady;
      prev_data = outData;
      if (outWriteEnable) begin
         got_q.push_back(int'(outData));
         last_wr_cyc = cyc;
      end
      if (outDone) begin
         done_cnt++;
         done_cyc     = cyc;
         frame_active = 1'b0;
      end
      if (outError) begin
         err_cnt++;
         busy_at_err  = outBusy;
         frame_active = 1'b0;
      end
      if (inByteValid && outByteReady) begin
         send_idx++;
         accepted++;
      end
      @(posedge inClock);
      #1;
      drive();
   endtask

   task automatic clear_tracking();
      got_q.delete();
      send_idx = 0; gap_left = 0; full_left = 0;
      gap_used = 1'b0; win0 = 1'b0; win1 = 1'b0; abort_sent = 1'b0;
      done_cnt = 0; err_cnt = 0; ready_seen = 0; accepted = 0;
      last_wr_cyc = 0; done_cyc = 0; prev_gap = 1'b0; busy_at_err = 1'b1;
   endtask

   // Caller fills tx_q with exactly len bytes before calling.
   task automatic run_frame(input int len, input int fmode, input int gidx, input bit rstart,
                            input bit vrand, input bit abrt);
      int exp_q[$];
      int budget;
      int n_at_abort;
      for (int i = 0; i < 8; i++) exp_q.push_back(0);
      exp_q.push_back('h7);
      exp_q.push_back('hA);
      exp_q.push_back(len % 16);
      exp_q.push_back(len / 16);
      foreach (tx_q[i]) begin
         exp_q.push_back(int'(tx_q[i]) % 16);
         exp_q.push_back(int'(tx_q[i]) / 16);
      end
      clear_tracking();
      full_mode = fmode; gap_idx = gidx; gap_len = 10;
      rand_start = rstart; valid_rand = vrand; abort_mode = abrt;
      inLength = 7'(len);
      inStart = 1'b1;
      frame_active = 1'b1;
      tick();
      budget = 0;
      while (frame_active && budget < 3000) begin
         tick();
         budget++;
      end
      check_eq("frame_finished_in_budget", frame_active, 0);
      frame_active = 1'b0;
      if (abrt) begin
         n_at_abort = got_q.size();
         repeat (20) tick();
         check_eq("abort_error_once", err_cnt, 1);
         check_eq("abort_no_done", done_cnt, 0);
         check_eq("abort_busy_low", busy_at_err, 0);
         check_eq("abort_no_more_writes", got_q.size(), n_at_abort);
         check_eq("abort_write_count", (n_at_abort == 14 || n_at_abort == 15), 1);
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("abort_nib%0d", i), got_q[i], exp_q[i]);
      end else begin
         repeat (3) tick();
         check_eq("done_once", done_cnt, 1);
         check_eq("no_error", err_cnt, 0);
         check_eq("done_after_last_write", done_cyc - last_wr_cyc, 1);
         check_eq("idle_after_done", outBusy, 0);
         check_eq("write_count", got_q.size(), 12 + 2 * len);
         check_eq("bytes_accepted", accepted, len);
         if (len == 0) check_eq("ready_never_len0", ready_seen, 0);
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("nib%0d", i), got_q[i], exp_q[i]);
      end
   endtask

   task automatic fill_random(input int len);
      tx_q.delete();
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
   endtask

   initial begin
      int n_wr, d0, e0, budget, len;
      clear_tracking();
      gap_idx = -1; full_mode = 0; frame_active = 1'b0;
      #3;
      check_eq("rst_data", outData, 0);
      check_eq("rst_we", outWriteEnable, 0);
      check_eq("rst_ready", outByteReady, 0);
      check_eq("rst_busy", outBusy, 0);
      check_eq("rst_done", outDone, 0);
      check_eq("rst_error", outError, 0);
      @(posedge inClock);
      #1 inReset = 1'b1;

      // Reference frame: len 2, bytes 3C 91
      tx_q.delete();
      tx_q.push_back(8'h3C);
      tx_q.push_back(8'h91);
      run_frame(2, 0, -1, 0, 0, 0);
      // Empty payload
      tx_q.delete();
      run_frame(0, 0, -1, 0, 0, 0);
      // FIFO stalls in SFD and PAYLOAD
      tx_q.delete();
      tx_q.push_back(8'h5E);
      run_frame(1, 2, -1, 0, 0, 0);
      // Upstream gap before the second byte
      fill_random(3);
      run_frame(3, 0, 1, 0, 0, 0);
      // Abort during byte 2, then a clean frame
      fill_random(4);
      run_frame(4, 0, -1, 0, 0, 1);
      fill_random(4);
      run_frame(4, 1, -1, 0, 1, 0);

      // Abort while idle does nothing
      e0 = err_cnt;
      inAbort = 1'b1;
      tick();
      tick();
      check_eq("idle_abort_no_error", err_cnt, e0);
      check_eq("idle_abort_not_busy", outBusy, 0);

      // Asynchronous reset mid-PHR
      fill_random(5);
      clear_tracking();
      gap_idx = -1; full_mode = 0; rand_start = 0; valid_rand = 0; abort_mode = 0;
      inLength = 7'd5;
      inStart = 1'b1;
      frame_active = 1'b1;
      tick();
      budget = 0;
      while (got_q.size() < 10 && budget < 100) begin
         tick();
         budget++;
      end
      check_eq("reached_phr", got_q.size(), 10);
      frame_active = 1'b0;
      #2 inReset = 1'b0;
      #1;
      check_eq("async_rst_data", outData, 0);
      check_eq("async_rst_we", outWriteEnable, 0);
      check_eq("async_rst_ready", outByteReady, 0);
      check_eq("async_rst_busy", outBusy, 0);
      check_eq("async_rst_done", outDone, 0);
      check_eq("async_rst_error", outError, 0);
      n_wr = got_q.size(); d0 = done_cnt; e0 = err_cnt;
      repeat (3) tick();
      inReset = 1'b1;
      repeat (5) tick();
      check_eq("rst_no_more_writes", got_q.size(), n_wr);
      check_eq("rst_no_done", done_cnt, d0);
      check_eq("rst_no_error", err_cnt, e0);

      // Extra inStart pulses while busy must be ignored
      fill_random(6);
      run_frame(6, 0, -1, 1, 0, 0);
      // Longest frame with stalls
      fill_random(127);
      run_frame(127, 1, -1, 0, 1, 0);
      // Random mixes
      for (int k = 0; k < 8; k++) begin
         len = $urandom_range(0, 40);
         fill_random(len);
         run_frame(len, $urandom_range(0, 1), (len > 1) ? int'($urandom_range(0, len - 1)) : -1,
                   1'($urandom), 1'($urandom), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
